// File: rtl/sclk_fifo_lut.sv
// Single-clock FIFO over a distributed-RAM array with a registered read port.
// Occupancy, full and empty all come from one registered level counter.
module sclk_fifo_lut #(
   parameter int LOG2_FIFO_DEPTH = 3,
   parameter int FIFO_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       srst,
   output logic [LOG2_FIFO_DEPTH:0]   level,
   input  logic                       ren,
   output logic [FIFO_WIDTH-1:0]      rdata,
   output logic                       rempty,
   input  logic                       wen,
   input  logic [FIFO_WIDTH-1:0]      wdata,
   output logic                       wfull
);

   localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
   localparam logic [LOG2_FIFO_DEPTH:0] FULL_LVL = DEPTH[LOG2_FIFO_DEPTH:0];

   logic [FIFO_WIDTH-1:0]      mem_q [DEPTH];
   logic [LOG2_FIFO_DEPTH-1:0] wptr_q, wptr_d;
   logic [LOG2_FIFO_DEPTH-1:0] rptr_q, rptr_d;
   logic [LOG2_FIFO_DEPTH:0]   level_q, level_d;
   logic [FIFO_WIDTH-1:0]      rdata_q;
   logic                       wr_acc, rd_acc;

   assign rempty = (level_q == '0);
   assign wfull  = (level_q == FULL_LVL);

   // Reset overrides both requests, so nothing moves in a reset cycle.
   assign wr_acc = wen & ~wfull  & ~srst;
   assign rd_acc = ren & ~rempty & ~srst;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage and read register are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wptr_q] <= wdata;
   end

   // Read samples the old word when both ports hit the same address.
   always_ff @(posedge clk) begin
      if (rd_acc) rdata_q <= mem_q[rptr_q];
   end

   assign level = level_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_sclk_fifo_lut.sv
// Directed bench for sclk_fifo_lut: a queue model checked every cycle on the
// falling edge, plus literal expectations taken straight from the test plan.
module tb_sclk_fifo_lut;

   localparam int L = 3;
   localparam int W = 32;
   localparam int DEPTH = 1 << L;

   logic           clk = 1'b0;
   logic           srst, ren, wen;
   logic [W-1:0]   wdata;
   logic [L:0]     level;
   logic [W-1:0]   rdata;
   logic           rempty, wfull;

   sclk_fifo_lut #(.LOG2_FIFO_DEPTH(L), .FIFO_WIDTH(W)) dut (
      .clk    (clk),
      .srst   (srst),
      .level  (level),
      .ren    (ren),
      .rdata  (rdata),
      .rempty (rempty),
      .wen    (wen),
      .wdata  (wdata),
      .wfull  (wfull)
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   bit          chk_en = 1'b0;
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_rdata;
   bit          m_rvalid = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // FIFO semantics in queue form, decided on the occupancy before the edge.
   task automatic model_edge(input bit r, input bit rs, input bit w, input logic [W-1:0] d);
      bit do_r, do_w;
      if (rs) begin
         m_q.delete();
         return;
      end
      do_r = r && (m_q.size() != 0);
      do_w = w && (m_q.size() != DEPTH);
      if (do_r) begin
         m_rdata  = m_q.pop_front();
         m_rvalid = 1'b1;
      end
      if (do_w) m_q.push_back(d);
   endtask

   task automatic step(input bit rs, input bit r, input bit w, input logic [W-1:0] d);
      @(negedge clk);
      srst = rs; ren = r; wen = w; wdata = d;
      @(posedge clk);
      model_edge(r, rs, w, d);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("level",  {{(W-L-1){1'b0}}, level}, m_q.size());
         chk("rempty", {{(W-1){1'b0}}, rempty}, (m_q.size() == 0) ? 1 : 0);
         chk("wfull",  {{(W-1){1'b0}}, wfull},  (m_q.size() == DEPTH) ? 1 : 0);
         if (m_rvalid) chk("rdata", rdata, m_rdata);
      end
   end

   initial begin
      srst = 1'b1; ren = 1'b0; wen = 1'b0; wdata = '0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_level",  {28'd0, level}, 0);
      chk("rst_rempty", {31'd0, rempty}, 1);
      chk("rst_wfull",  {31'd0, wfull}, 0);

      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 1, i);
         chk("fill_level", {28'd0, level}, i);
         chk("fill_rempty", {31'd0, rempty}, 0);
      end
      chk("full_wfull", {31'd0, wfull}, 1);

      step(0, 0, 1, 9);
      chk("ovf_level", {28'd0, level}, 8);
      chk("ovf_wfull", {31'd0, wfull}, 1);

      for (int i = 1; i <= 8; i++) begin
         step(0, 1, 0, 0);
         chk("drain_rdata", rdata, i);
         chk("drain_level", {28'd0, level}, 8 - i);
      end
      chk("drain_rempty", {31'd0, rempty}, 1);

      step(0, 1, 0, 0);
      chk("udf_rdata", rdata, 8);
      chk("udf_level", {28'd0, level}, 0);

      step(0, 0, 1, 32'h19);
      chk("one_level", {28'd0, level}, 1);

      step(0, 1, 1, 32'h1E);
      chk("rw_rdata0", rdata, 32'h19);
      step(0, 1, 1, 32'h1F);
      chk("rw_rdata1", rdata, 32'h1E);
      step(0, 1, 1, 32'h20);
      chk("rw_rdata2", rdata, 32'h1F);
      step(0, 1, 1, 32'h21);
      chk("rw_rdata3", rdata, 32'h20);
      chk("rw_level", {28'd0, level}, 1);

      // Mixed traffic well past a pointer wrap.
      for (int i = 0; i < 40; i++)
         step(0, (i % 3) != 0, (i % 4) != 3, 32'h100 + i);

      // Top up to full, then read+write on full drops the write.
      for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h200 + i);
      chk("top_level", {28'd0, level}, 8);
      step(0, 1, 1, 32'hDEAD);
      chk("rwfull_level", {28'd0, level}, 7);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
      chk("rwfull_drop", rdata == 32'hDEAD ? 32'd1 : 32'd0, 0);

      // Simultaneous read+write on empty: write only, rdata held.
      step(0, 1, 1, 32'h300);
      chk("rwempty_level", {28'd0, level}, 1);

      // Mid-stream reset with both requests up.
      step(0, 0, 1, 32'h301);
      step(0, 0, 1, 32'h302);
      step(1, 1, 1, 32'h303);
      chk("mrst_level", {28'd0, level}, 0);
      chk("mrst_rempty", {31'd0, rempty}, 1);
      step(0, 1, 0, 0);
      chk("mrst_level2", {28'd0, level}, 0);
      step(0, 0, 1, 32'h400);
      step(0, 1, 0, 0);
      chk("post_rst_rdata", rdata, 32'h400);
      step(0, 0, 0, 0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
